// File: rtl/spi_pkg.sv
// Shared constants for the SPI byte PHY: transfer width, FSM encodings and idle MISO level.
package spi_pkg;

    localparam int          SPI_DATA_W    = 8;
    localparam logic [0:0]  SPI_ST_IDLE   = 1'b0;
    localparam logic [0:0]  SPI_ST_ACTIVE = 1'b1;
    localparam logic        SPI_IDLE_MISO = 1'b1;

endpackage

// File: rtl/spi_byte_phy_if.sv
// Byte-side bus between the SPI PHY (master modport) and the command layer (slave modport).
interface spi_byte_phy_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_byte;
    logic              tx_req;
    logic [DATA_W-1:0] rx_byte;
    logic              rx_valid;
    logic              rx_first;
    logic              frame_start;
    logic              frame_end;
    logic              frame_partial;

    modport master (
        input  tx_byte,
        output tx_req, rx_byte, rx_valid, rx_first,
        output frame_start, frame_end, frame_partial
    );

    modport slave (
        output tx_byte,
        input  tx_req, rx_byte, rx_valid, rx_first,
        input  frame_start, frame_end, frame_partial
    );
endinterface

// File: rtl/spi_edge_det.sv
// Edge detector on an already-synchronized level; rise/fall are combinational, high for the one clk
// where the level differs from its registered copy. No backpressure.
module spi_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lvl,
    output logic rise,
    output logic fall
);
    logic lvl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q <= RST_VAL;
        end else begin
            lvl_q <= lvl;
        end
    end

    assign rise =  lvl & ~lvl_q;
    assign fall = ~lvl &  lvl_q;
endmodule

// File: rtl/spi_byte_phy.sv
// SPI mode-0 byte PHY: deserializes MOSI, serializes tx_byte on MISO; strobes 1 clk after the edge.
// No backpressure: consumer must present tx_byte within 2 clk of tx_req.
module spi_byte_phy
    import spi_pkg::*;
#(
    parameter int   DATA_W    = SPI_DATA_W,
    parameter logic IDLE_MISO = SPI_IDLE_MISO
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sck_sync,
    input  logic           csb_sync,
    input  logic           mosi_sync,
    output logic           miso,
    spi_byte_phy_if.master bus
);
    localparam int            CW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    logic              sck_rise, sck_fall;
    logic              csb_rise, csb_fall;
    logic [0:0]        state;
    logic [CW-1:0]     bit_cnt;
    logic              first_flag;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-2:0] rx_shift;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] rx_byte_q;
    logic              rx_valid_q, rx_first_q, tx_req_q;
    logic              frame_start_q, frame_end_q, frame_partial_q;

    spi_edge_det #(.RST_VAL(1'b0)) u_sck_det (
        .clk   (clk),
        .rst_n (rst_n),
        .lvl   (sck_sync),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_edge_det #(.RST_VAL(1'b1)) u_csb_det (
        .clk   (clk),
        .rst_n (rst_n),
        .lvl   (csb_sync),
        .rise  (csb_rise),
        .fall  (csb_fall)
    );

    // Only DATA_W-1 bits are kept; the completed byte is formed with the incoming bit.
    assign rx_next = {rx_shift, mosi_sync};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= SPI_ST_IDLE;
            bit_cnt         <= '0;
            first_flag      <= 1'b0;
            tx_shift        <= '0;
            rx_shift        <= '0;
            rx_byte_q       <= '0;
            rx_valid_q      <= 1'b0;
            rx_first_q      <= 1'b0;
            tx_req_q        <= 1'b0;
            frame_start_q   <= 1'b0;
            frame_end_q     <= 1'b0;
            frame_partial_q <= 1'b0;
        end else begin
            rx_valid_q      <= 1'b0;
            rx_first_q      <= 1'b0;
            tx_req_q        <= 1'b0;
            frame_start_q   <= 1'b0;
            frame_end_q     <= 1'b0;
            frame_partial_q <= 1'b0;
            case (state)
                SPI_ST_IDLE: begin
                    // An sck rise coincident with select is dropped: mode 0 idles sck low.
                    if (csb_fall) begin
                        state         <= SPI_ST_ACTIVE;
                        frame_start_q <= 1'b1;
                        bit_cnt       <= '0;
                        first_flag    <= 1'b1;
                        tx_shift      <= bus.tx_byte;
                    end
                end
                default: begin
                    if (csb_rise) begin
                        state           <= SPI_ST_IDLE;
                        frame_end_q     <= 1'b1;
                        frame_partial_q <= (bit_cnt != '0);
                        bit_cnt         <= '0;
                    end else if (sck_rise) begin
                        rx_shift <= rx_next[DATA_W-2:0];
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt    <= '0;
                            rx_byte_q  <= rx_next;
                            rx_valid_q <= 1'b1;
                            rx_first_q <= first_flag;
                            first_flag <= 1'b0;
                            tx_req_q   <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end else if (sck_fall) begin
                        if (bit_cnt == '0) begin
                            tx_shift <= bus.tx_byte;
                        end else begin
                            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                        end
                    end
                end
            endcase
        end
    end

    assign miso              = (state == SPI_ST_ACTIVE) ? tx_shift[DATA_W-1] : IDLE_MISO;
    assign bus.rx_byte       = rx_byte_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_first      = rx_first_q;
    assign bus.tx_req        = tx_req_q;
    assign bus.frame_start   = frame_start_q;
    assign bus.frame_end     = frame_end_q;
    assign bus.frame_partial = frame_partial_q;
endmodule

// File: tb/tb_spi_byte_phy.sv
// Directed bench for spi_byte_phy: drives synchronized SPI levels, logs byte-side strobes at negedge.
module tb_spi_byte_phy;
    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic sck_sync  = 1'b0;
    logic csb_sync  = 1'b1;
    logic mosi_sync = 1'b0;
    logic miso;

    spi_byte_phy_if #(.DATA_W(8)) bus ();

    spi_byte_phy #(.DATA_W(8), .IDLE_MISO(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sck_sync  (sck_sync),
        .csb_sync  (csb_sync),
        .mosi_sync (mosi_sync),
        .miso      (miso),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int rx_cnt = 0, txr_cnt = 0, fs_cnt = 0, fe_cnt = 0, part_cnt = 0, both_cnt = 0;
    logic [7:0] rx_q[$];
    logic       first_q[$];
    logic [7:0] tx_q[$];

    // Consumer model: logs strobes and answers each tx_req with the next queued byte.
    always @(negedge clk) begin
        if (bus.rx_valid) begin
            rx_cnt++;
            rx_q.push_back(bus.rx_byte);
            first_q.push_back(bus.rx_first);
        end
        if (bus.tx_req) begin
            txr_cnt++;
            if (tx_q.size() > 0) bus.tx_byte = tx_q.pop_front();
        end
        if (bus.frame_start) fs_cnt++;
        if (bus.frame_end) begin
            fe_cnt++;
            if (bus.frame_partial) part_cnt++;
        end
        if (bus.frame_start && bus.frame_end) both_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bit_rise(input logic b, output logic m);
        mosi_sync = b;
        tick(3);
        m = miso;
        sck_sync = 1'b1;
        tick(4);
    endtask

    task automatic bit_fall();
        sck_sync = 1'b0;
    endtask

    task automatic xfer_byte(input logic [7:0] mo, output logic [7:0] mi);
        logic m;
        for (int i = 7; i >= 0; i--) begin
            bit_rise(mo[i], m);
            mi[i] = m;
            bit_fall();
        end
    endtask

    task automatic frame_open();
        csb_sync = 1'b0;
        tick(3);
    endtask

    task automatic frame_close();
        tick(3);
        csb_sync = 1'b1;
        tick(3);
    endtask

    initial begin
        logic [7:0] mi;
        logic       m;
        int         rx0, txr0, fs0, fe0, pt0;

        // Reset state
        bus.tx_byte = 8'h00;
        tick(3);
        check_eq("rst_miso", 32'(miso), 32'd1);
        check_eq("rst_rx_byte", 32'(bus.rx_byte), 32'h00);
        check_eq("rst_pulses", 32'({bus.rx_valid, bus.rx_first, bus.tx_req,
                 bus.frame_start, bus.frame_end, bus.frame_partial}), 32'd0);
        rst_n = 1'b1;
        tick(3);

        // 1: single byte frame
        bus.tx_byte = 8'h3C;
        frame_open();
        check_eq("t1_frame_start", 32'(fs_cnt), 32'd1);
        xfer_byte(8'hA5, mi);
        tick(3);
        check_eq("t1_miso_byte", 32'(mi), 32'h3C);
        check_eq("t1_rx_cnt", 32'(rx_cnt), 32'd1);
        check_eq("t1_rx_byte", 32'(rx_q[0]), 32'hA5);
        check_eq("t1_rx_first", 32'(first_q[0]), 32'd1);
        check_eq("t1_tx_req", 32'(txr_cnt), 32'd1);
        frame_close();
        check_eq("t1_frame_end", 32'(fe_cnt), 32'd1);
        check_eq("t1_partial", 32'(part_cnt), 32'd0);
        check_eq("t1_idle_miso", 32'(miso), 32'd1);

        // 2: three-byte frame with consumer refills
        rx_q.delete();
        first_q.delete();
        bus.tx_byte = 8'h11;
        tx_q.push_back(8'h22);
        tx_q.push_back(8'h33);
        frame_open();
        xfer_byte(8'h01, mi);
        check_eq("t2_miso0", 32'(mi), 32'h11);
        xfer_byte(8'h80, mi);
        check_eq("t2_miso1", 32'(mi), 32'h22);
        xfer_byte(8'hFF, mi);
        check_eq("t2_miso2", 32'(mi), 32'h33);
        frame_close();
        check_eq("t2_rx_cnt", 32'(rx_cnt), 32'd4);
        check_eq("t2_rx0", 32'({first_q[0], rx_q[0]}), 32'h101);
        check_eq("t2_rx1", 32'({first_q[1], rx_q[1]}), 32'h080);
        check_eq("t2_rx2", 32'({first_q[2], rx_q[2]}), 32'h0FF);
        check_eq("t2_tx_req", 32'(txr_cnt), 32'd4);
        check_eq("t2_frame_end", 32'(fe_cnt), 32'd2);

        // 3: partial frame after 5 bits
        rx0 = rx_cnt;
        frame_open();
        for (int i = 0; i < 5; i++) begin
            bit_rise(1'(i & 1), m);
            bit_fall();
        end
        frame_close();
        check_eq("t3_frame_end", 32'(fe_cnt), 32'd3);
        check_eq("t3_partial", 32'(part_cnt), 32'd1);
        check_eq("t3_no_rx", 32'(rx_cnt), 32'(rx0));
        check_eq("t3_rx_hold", 32'(bus.rx_byte), 32'hFF);

        // 4: sck activity while deselected
        rx0 = rx_cnt; txr0 = txr_cnt; fs0 = fs_cnt;
        xfer_byte(8'h96, mi);
        tick(3);
        check_eq("t4_miso_idle", 32'(mi), 32'hFF);
        check_eq("t4_no_rx", 32'(rx_cnt), 32'(rx0));
        check_eq("t4_no_tx_req", 32'(txr_cnt), 32'(txr0));
        check_eq("t4_no_start", 32'(fs_cnt), 32'(fs0));

        // 5: reset mid-frame with csb held low
        rx_q.delete();
        first_q.delete();
        bus.tx_byte = 8'hC3;
        frame_open();
        for (int i = 0; i < 4; i++) begin
            bit_rise(1'b1, m);
            bit_fall();
        end
        tick(3);
        rst_n = 1'b0;
        tick(2);
        check_eq("t5_rst_miso", 32'(miso), 32'd1);
        check_eq("t5_rst_rx_byte", 32'(bus.rx_byte), 32'h00);
        check_eq("t5_rst_pulses", 32'({bus.rx_valid, bus.tx_req, bus.frame_start, bus.frame_end}), 32'd0);
        fs0 = fs_cnt;
        rst_n = 1'b1;
        tick(3);
        check_eq("t5_restart", 32'(fs_cnt), 32'(fs0 + 1));
        xfer_byte(8'h5A, mi);
        tick(3);
        check_eq("t5_miso_byte", 32'(mi), 32'hC3);
        check_eq("t5_rx", 32'({first_q[0], rx_q[0]}), 32'h15A);
        fe0 = fe_cnt; pt0 = part_cnt;
        frame_close();
        check_eq("t5_frame_end", 32'(fe_cnt), 32'(fe0 + 1));
        check_eq("t5_partial", 32'(part_cnt), 32'(pt0));

        // 6: csb rise coincident with sck fall
        rx0 = rx_cnt; fe0 = fe_cnt; pt0 = part_cnt;
        bus.tx_byte = 8'h00;
        frame_open();
        bit_rise(1'b0, m);
        bit_fall();
        bit_rise(1'b1, m);
        bit_fall();
        bit_rise(1'b1, m);
        check_eq("t6_miso_active", 32'(miso), 32'd0);
        sck_sync = 1'b0;
        csb_sync = 1'b1;
        tick(1);
        check_eq("t6_miso_idle", 32'(miso), 32'd1);
        tick(3);
        check_eq("t6_frame_end", 32'(fe_cnt), 32'(fe0 + 1));
        check_eq("t6_partial", 32'(part_cnt), 32'(pt0 + 1));
        check_eq("t6_no_rx", 32'(rx_cnt), 32'(rx0));

        check_eq("start_end_overlap", 32'(both_cnt), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
